wb_master_if: RTL and testbench
===============================

# wb_master_if

Wishbone classic single-transfer initiator. Accepts one read or write command on a valid/ready command port and runs it as a single Wishbone cycle to the peripheral bus, e.g. to the GPIO and timer responders at 0x400. Returns read data and status on a one-cycle response strobe. It sits between the CPU-side load/store path (or a test sequencer) and the Wishbone interconnect.

## Interface
- TIMEOUT_CYCLES, 16: cycles `cyc_o` may stay high without `ack_i`/`err_i` before forced termination. Minimum 1.
- clk_i  in  1  system clock; all logic on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with `cmd_valid_i`
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  32  byte address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte selects
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_dat_o  out  32  read data; 0 for writes and errors
- rsp_err_o  out  1  bus error or timeout; valid with `rsp_valid_o`
- adr_o  out  32  Wishbone address
- dat_o  out  32  Wishbone write data
- dat_i  in  32  Wishbone read data
- we_o  out  1  Wishbone write enable
- sel_o  out  4  Wishbone byte selects
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe; always equal to `cyc_o`
- ack_i  in  1  Wishbone acknowledge
- err_i  in  1  Wishbone error

## Operation
- States: IDLE, BUS.
- IDLE:
  - `cmd_ready_o` = 1.
  - On `cmd_valid_i`: register adr/dat/sel/we onto the bus outputs, set `cyc_o`/`stb_o`, clear the timeout counter, go to BUS.
- BUS:
  - `cmd_ready_o` = 0. Bus outputs are held stable.
  - `cmd_valid_i` is ignored.
- BUS exit conditions, in priority order:
  - `err_i`: terminate with `rsp_err_o`=1, `rsp_dat_o`=0.
  - `ack_i`: terminate with `rsp_err_o`=0; `rsp_dat_o` = `dat_i` on a read, 0 on a write.
  - Timeout, counter == TIMEOUT_CYCLES-1: terminate with `rsp_err_o`=1, `rsp_dat_o`=0.
- `ack_i` and `err_i` together: error wins. `ack_i` on the timeout cycle: ack wins.
- Termination (registered):
  - Next cycle: `cyc_o`/`stb_o`=0, `rsp_valid_o`=1 for exactly one cycle, state IDLE.
  - `adr_o`/`dat_o`/`sel_o`/`we_o` return to 0.
- `ack_i`/`err_i` arriving while in IDLE are ignored.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- Reset (`rst_ni` low at a clock edge) forces, from the next edge:
  - all outputs 0 except `cmd_ready_o`=1;
  - state IDLE, counter 0.
- Reset mid-transaction abandons the cycle: `cyc_o` drops and no response is produced.
- Command accepted at edge N:
  - `cyc_o` high from N+1;
  - earliest `ack_i` sampled at N+2;
  - `rsp_valid_o` high in N+2..N+3;
  - next command accepted at edge N+3.
- `cyc_o` is always low for at least one cycle between transfers. Responders that register `ack_o` therefore see a fresh request each time.
- Timeout: `cyc_o` high for exactly TIMEOUT_CYCLES cycles, then `rsp_valid_o`.
- `rsp_*` outputs are registered. `rsp_dat_o`/`rsp_err_o` hold their value until the next termination.

## Configuration
- `WB_MASTER_IF_TIMEOUT_EN` defined:
  - timeout counter and forced termination are present;
  - TIMEOUT_CYCLES is honoured.
- Not defined:
  - no counter logic;
  - BUS is left only on `ack_i`/`err_i`, and the block waits indefinitely;
  - TIMEOUT_CYCLES is accepted but unused.

## Structure
- Shared package `wb_pkg`:
  - state encoding (IDLE=0, BUS=1);
  - Wishbone width constants (address 32, data 32, sel 4);
  - default TIMEOUT_CYCLES.
- One sub-module, `wb_timeout_cnt`:
  - clear/enable inputs, terminal-count output;
  - instantiated only under `WB_MASTER_IF_TIMEOUT_EN`.

## Test plan
- Write 0x000000A5, adr 0x400, sel 0xF; responder acks one cycle after `cyc_o` rises.
  - Expect `cyc_o` high for 2 cycles with `adr_o`=0x400, `dat_o`=0xA5, `we_o`=1.
  - Then `rsp_valid_o` pulse with `rsp_err_o`=0 and `rsp_dat_o`=0.
- Read adr 0x400; responder returns `dat_i`=0x000000A5 with `ack_i`.
  - Expect `rsp_dat_o`=0xA5, `rsp_err_o`=0.
  - `cmd_ready_o` low from acceptance through termination.
- Read with no responder, TIMEOUT_CYCLES=16, `WB_MASTER_IF_TIMEOUT_EN` defined.
  - Expect `cyc_o` high exactly 16 cycles, then `rsp_valid_o` with `rsp_err_o`=1 and `rsp_dat_o`=0.
- `ack_i`=1 and `err_i`=1 together.
  - Expect `rsp_err_o`=1.
- Timeout build, `ack_i` arriving on the 16th cycle.
  - Expect `rsp_err_o`=0 and valid data.
- `rst_ni` low for 1 cycle while `cyc_o`=1.
  - Expect all outputs 0 and `cmd_ready_o`=1 next cycle, and no `rsp_valid_o`.
  - A stale `ack_i` the following cycle is ignored.
- Back-to-back `cmd_valid_i` held high for 3 writes with single-cycle acks.
  - Expect 3 responses and one idle cycle (`cyc_o`=0) between consecutive cycles.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone single-transfer initiator:
// FSM state encoding, bus widths and the default timeout.
package wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } wb_state_e;

  localparam int WB_ADR_W           = 32;
  localparam int WB_DAT_W           = 32;
  localparam int WB_SEL_W           = 4;
  localparam int WB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/wb_master_if_if.sv
// Wishbone classic bus bundle between the initiator (master) and a responder or
// interconnect (slave).
interface wb_master_if_if;
  import wb_pkg::*;

  logic [WB_ADR_W-1:0] adr_o;
  logic [WB_DAT_W-1:0] dat_o;
  logic [WB_DAT_W-1:0] dat_i;
  logic                we_o;
  logic [WB_SEL_W-1:0] sel_o;
  logic                cyc_o;
  logic                stb_o;
  logic                ack_i;
  logic                err_i;

  modport master (
    output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    output dat_i, ack_i, err_i
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Saturating bus-cycle counter; tc_o flags the last cycle a transfer may stay
// open without a responder answer.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_master_if.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle out,
// one response pulse back. Optional timeout under WB_MASTER_IF_TIMEOUT_EN.
module wb_master_if
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  wb_master_if_if.master      bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_master_if: TIMEOUT_CYCLES must be at least 1");
  end

  wb_state_e           state_q, state_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic                we_q, we_d;
  logic                cyc_q, cyc_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic                timeout_hit;

`ifdef WB_MASTER_IF_TIMEOUT_EN
  logic cnt_clr;
  logic cnt_en;

  assign cnt_clr = (state_q == IDLE) && cmd_valid_i;
  assign cnt_en  = (state_q == BUS);

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          we_d    = cmd_we_i;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (bus.err_i || bus.ack_i || timeout_hit) begin
          state_d     = IDLE;
          adr_d       = '0;
          dat_d       = '0;
          sel_d       = '0;
          we_d        = 1'b0;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          // Error outranks ack; ack outranks a timeout landing in the same cycle.
          rsp_err_d   = bus.err_i || !bus.ack_i;
          rsp_dat_d   = (!bus.err_i && bus.ack_i && !we_q) ? bus.dat_i : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

  assign bus.adr_o = adr_q;
  assign bus.dat_o = dat_q;
  assign bus.sel_o = sel_q;
  assign bus.we_o  = we_q;
  assign bus.cyc_o = cyc_q;
  assign bus.stb_o = cyc_q;

endmodule

// File: tb/tb_wb_master_if.sv
// Directed self-checking bench for wb_master_if; timeout cases follow
// WB_MASTER_IF_TIMEOUT_EN.
module tb_wb_master_if;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  wb_master_if_if bus ();

  wb_master_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .bus         (bus.master)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one command, answer it per the arguments, then check the response.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel, input int wait_cyc,
                      input logic give_ack, input logic give_err, input logic [31:0] rdata,
                      input int exp_cyc, input logic [31:0] exp_dat, input logic exp_err);
    int   cyc_cnt;
    logic bad_hold;
    logic got;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    cmd_adr_i   = 32'hDEAD_BEEF;
    cyc_cnt  = 0;
    bad_hold = 1'b0;
    got      = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (bus.cyc_o) begin
        cyc_cnt++;
        if (bus.adr_o !== adr || bus.dat_o !== dat || bus.we_o !== we ||
            bus.sel_o !== sel || bus.stb_o !== 1'b1 || cmd_ready_o !== 1'b0)
          bad_hold = 1'b1;
        if (cyc_cnt == wait_cyc + 1) begin
          bus.ack_i = give_ack;
          bus.err_i = give_err;
          bus.dat_i = rdata;
        end
      end else if (rsp_valid_o) begin
        got = 1'b1;
      end
      if (!got) begin
        tick();
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.dat_i = '0;
      end
    end
    check({tag, " rsp_seen"}, 32'(got), 32'd1);
    check({tag, " cyc_len"}, cyc_cnt, exp_cyc);
    check({tag, " rsp_dat"}, rsp_dat_o, exp_dat);
    check({tag, " rsp_err"}, 32'(rsp_err_o), 32'(exp_err));
    check({tag, " bus_held"}, 32'(bad_hold), 32'd0);
    check({tag, " bus_idle"}, bus.adr_o | bus.dat_o | 32'(bus.sel_o) | 32'(bus.we_o) |
          32'(bus.cyc_o) | 32'(bus.stb_o), 32'd0);
    check({tag, " ready_back"}, 32'(cmd_ready_o), 32'd1);
    tick();
    check({tag, " pulse_1cyc"}, 32'(rsp_valid_o), 32'd0);
    check({tag, " dat_hold"}, rsp_dat_o, exp_dat);
  endtask

  initial begin
    int accepts, rsps, gap, gap_bad, seen_cyc;
    logic prev_cyc;
    bus.dat_i = '0;
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;

    rst_ni = 1'b0;
    tick();
    tick();
    check("rst cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst cyc", 32'(bus.cyc_o), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst adr", bus.adr_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    // ack/err while idle must not produce anything
    bus.ack_i = 1'b1;
    bus.err_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    check("idle_ack rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("idle_ack cyc", 32'(bus.cyc_o), 32'd0);

    xfer("wr_a5", 1'b1, 32'h400, 32'hA5, 4'hF, 1, 1'b1, 1'b0, 32'h0, 2, 32'h0, 1'b0);
    xfer("rd_a5", 1'b0, 32'h400, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'hA5, 2, 32'hA5, 1'b0);
    xfer("wr_dat_i_ignored", 1'b1, 32'h404, 32'h1234_5678, 4'h3, 0, 1'b1, 1'b0,
         32'hFFFF_0000, 1, 32'h0, 1'b0);
    xfer("rd_ack_err", 1'b0, 32'h408, 32'h0, 4'hF, 2, 1'b1, 1'b1, 32'hCAFE_F00D,
         3, 32'h0, 1'b1);
    xfer("rd_ok2", 1'b0, 32'h40C, 32'h0, 4'h1, 0, 1'b1, 1'b0, 32'h0000_00C3, 1, 32'hC3, 1'b0);
    xfer("wr_err", 1'b1, 32'h410, 32'h77, 4'hC, 3, 1'b0, 1'b1, 32'h0, 4, 32'h0, 1'b1);

`ifdef WB_MASTER_IF_TIMEOUT_EN
    xfer("rd_timeout", 1'b0, 32'h500, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, TO, 32'h0, 1'b1);
    xfer("rd_ack_last", 1'b0, 32'h400, 32'h0, 4'hF, TO - 1, 1'b1, 1'b0, 32'h5A5A_5A5A,
         TO, 32'h5A5A_5A5A, 1'b0);
    xfer("rd_err_after_to", 1'b0, 32'h504, 32'h0, 4'hF, 0, 1'b0, 1'b1, 32'h0, 1, 32'h0, 1'b1);
`else
    xfer("rd_no_timeout", 1'b0, 32'h500, 32'h0, 4'hF, 40, 1'b1, 1'b0, 32'h0000_0042,
         41, 32'h42, 1'b0);
    xfer("rd_err_long", 1'b0, 32'h504, 32'h0, 4'hF, 20, 1'b0, 1'b1, 32'h0, 21, 32'h0, 1'b1);
`endif

    // Reset in the middle of a transfer; rsp_err_o is 1 from the previous transfer.
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 32'h400;
    cmd_dat_i   = 32'h11;
    cmd_sel_i   = 4'hF;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    check("mid_rst cyc_before", 32'(bus.cyc_o), 32'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("mid_rst cyc", 32'(bus.cyc_o), 32'd0);
    check("mid_rst bus", bus.adr_o | bus.dat_o | 32'(bus.sel_o) | 32'(bus.we_o) |
          32'(bus.stb_o), 32'd0);
    check("mid_rst rsp", 32'(rsp_valid_o) | 32'(rsp_err_o) | rsp_dat_o, 32'd0);
    check("mid_rst ready", 32'(cmd_ready_o), 32'd1);
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("stale_ack rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("stale_ack cyc", 32'(bus.cyc_o), 32'd0);
    tick();
    check("stale_ack rsp_valid2", 32'(rsp_valid_o), 32'd0);

    // Back-to-back writes with cmd_valid held; responder acks one cycle after cyc rises.
    accepts  = 0;
    rsps     = 0;
    gap      = 0;
    gap_bad  = 0;
    seen_cyc = 0;
    prev_cyc = 1'b0;
    cmd_we_i  = 1'b1;
    cmd_sel_i = 4'hF;
    cmd_adr_i = 32'h400;
    cmd_dat_i = 32'h100;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 60 && rsps < 3; i++) begin
      if (rsp_valid_o) rsps++;
      if (bus.cyc_o && !prev_cyc) begin
        if (seen_cyc > 0 && gap != 1) gap_bad++;
        seen_cyc++;
      end
      gap = bus.cyc_o ? 0 : gap + 1;
      bus.ack_i = bus.cyc_o && prev_cyc;
      prev_cyc  = bus.cyc_o;
      if (cmd_valid_i && cmd_ready_o) accepts++;
      tick();
      if (accepts == 3) cmd_valid_i = 1'b0;
      cmd_dat_i = cmd_dat_i + 32'h1;
    end
    bus.ack_i   = 1'b0;
    cmd_valid_i = 1'b0;
    check("b2b responses", rsps, 3);
    check("b2b accepts", accepts, 3);
    check("b2b cycles", seen_cyc, 3);
    check("b2b gap_bad", gap_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
